shift_sequencer: RTL and testbench



---
 rtl/shift_pkg.sv | 39 +++
 rtl/shift_sequencer_if.sv | 25 ++
 rtl/shift_step.sv | 22 ++
 rtl/shift_sequencer.sv | 85 ++++++++
 tb/tb_shift_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared opcodes, FSM encoding and barrel helper for the shift sequencer.
// The barrel helper serves the SHIFT_FASTPATH_EN build.
package shift_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASL = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Shift the low w bits of d by n single-bit steps; n >= w fully drains.
    function automatic logic [63:0] barrel(
        input logic [63:0] d,
        input int          w,
        input logic [1:0]  op,
        input int          n
    );
        logic [63:0] r;
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        r    = d & mask;
        for (int i = 0; i < 64; i++) begin
            if (i < n) begin
                case (op)
                    OP_LSL, OP_ASL: r = (r << 1) & mask;
                    OP_LSR:         r = r >> 1;
                    default:        r = (r >> 1) | (r & (64'd1 << (w - 1)));
                endcase
            end
        end
        return r & mask;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// master drives requests and consumes results; slave is the engine.
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_op, in_amt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_op, in_amt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_step.sv
// Combinational one-bit shift stage used on the data feedback path.
// Left ops shift in zero; ASR replicates the sign bit.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        unique case (1'b1)
            (op == OP_LSL) || (op == OP_ASL): q = {d[WIDTH-2:0], 1'b0};
            (op == OP_LSR):                   q = {1'b0, d[WIDTH-1:1]};
            (op == OP_ASR):                   q = {d[WIDTH-1], d[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: one bit per clock through shift_step.
// Define SHIFT_FASTPATH_EN to load the full result at acceptance instead.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  io,
    output logic              busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] step_q;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    amt_sat;

    assign amt_sat = (int'(io.in_amt) >= WIDTH) ? CW'(WIDTH)
                                                : CW'(io.in_amt);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d  (data_q),
        .op (op_q),
        .q  (step_q)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    op_d = io.in_op;
`ifdef SHIFT_FASTPATH_EN
                    data_d  = WIDTH'(barrel(64'(io.in_data), WIDTH,
                                            io.in_op, int'(amt_sat)));
                    cnt_d   = '0;
                    state_d = DONE;
`else
                    data_d  = io.in_data;
                    cnt_d   = amt_sat;
                    state_d = (amt_sat == '0) ? DONE : SHIFT;
`endif
                end
            end
            SHIFT: begin
                data_d = step_q;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.out_data  = data_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random
// requests against an arithmetic reference model.
module tb_shift_sequencer;

    localparam int W = 4;
    localparam int A = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(W), .AMT_W(A)) bus ();

    shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus),
        .busy  (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                           input logic [1:0] op,
                                           input int amt);
        int n;
        logic signed [W-1:0] s;
        n = (amt > W) ? W : amt;
        s = d;
        case (op)
            2'b01:   return d >> n;
            2'b11:   return W'(s >>> n);
            default: return W'(d << n);
        endcase
    endfunction

    function automatic int lat(input int amt);
`ifdef SHIFT_FASTPATH_EN
        return 0;
`else
        return (amt > W) ? W : amt;
`endif
    endfunction

    task automatic req(input logic [W-1:0] d, input logic [1:0] op,
                       input logic [A-1:0] amt, input int hold,
                       input string tag);
        int k;
        logic [W-1:0] e;
        e = model(d, op, int'(amt));
        chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_op    = op;
        bus.in_amt   = amt;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = W'($urandom);
        bus.in_op    = 2'($urandom);
        bus.in_amt   = A'($urandom);
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk({tag, ".lat"}, 32'(k), 32'(lat(int'(amt))));
        chk({tag, ".data"}, 32'(bus.out_data), 32'(e));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk({tag, ".hold_rdy"}, 32'(bus.in_ready), 32'd0);
            chk({tag, ".hold_vld"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_data"}, 32'(bus.out_data), 32'(e));
            bus.in_valid = 1'b1;
            bus.in_data  = W'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({tag, ".idle_rdy"}, 32'(bus.in_ready), 32'd1);
        chk({tag, ".idle_vld"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_op     = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst.rdy", 32'(bus.in_ready), 32'd1);
        chk("rst.vld", 32'(bus.out_valid), 32'd0);
        chk("rst.data", 32'(bus.out_data), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        req(4'b0110, 2'b00, 3'd1, 0, "lsl1");
        req(4'b1001, 2'b11, 3'd2, 0, "asr2");
        req(4'b1001, 2'b01, 3'd2, 0, "lsr2");
        req(4'b1001, 2'b10, 3'd1, 0, "asl1");
        req(4'b1011, 2'($urandom), 3'd0, 0, "amt0");
        req(4'b1000, 2'b11, 3'd6, 0, "sat_asr");
        req(4'b1000, 2'b00, 3'd7, 0, "sat_lsl");
        req(4'b0111, 2'b01, 3'd1, 3, "bp");
        req(4'b0011, 2'b00, 3'd2, 0, "after_bp");

        // abort mid-operation with an asynchronous reset
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0101;
        bus.in_op    = 2'b00;
        bus.in_amt   = 3'd3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.vld", 32'(bus.out_valid), 32'd0);
        chk("abort.data", 32'(bus.out_data), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        req(4'b1100, 2'b11, 3'd3, 0, "post_rst");

        for (int t = 0; t < 40; t++) begin
            req(W'($urandom), 2'($urandom), A'($urandom),
                $urandom_range(0, 2), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
